// File: rtl/vga_pixel_fetch.sv
// Per-pixel fetch stage of the VGA pipeline: picks the topmost active layer,
// resolves its byte address through a one-word read cache or a 32-bit SDRAM
// read, and presents the pixel one next_pixel later. Late pixels show as 0
// and set the sticky underrun flag.
module vga_pixel_fetch #(
    parameter int NUM_LAYERS = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     next_pixel,
    input  logic                     new_frame,
    input  logic [NUM_LAYERS-1:0]    layer_active,
    input  logic [26*NUM_LAYERS-1:0] layer_address,
    output logic                     mem_request,
    output logic [25:0]              mem_address,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [7:0]               pixel_out,
    output logic                     underrun
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] mem_address_q, mem_address_d;
    logic [7:0]  pixel_q, pixel_d;
    logic        underrun_q, underrun_d;
    logic        cache_valid_q, cache_valid_d;
    logic [23:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic [25:0] job_addr_q, job_addr_d;
    logic        job_blank_q, job_blank_d;
    logic        job_valid_q, job_valid_d;
    logic        ready_q, ready_d;
    logic [7:0]  result_q, result_d;
    // the in-flight read was issued for the job currently held
    logic        fetch_cur_q, fetch_cur_d;
    // the in-flight read was orphaned by new_frame; its data must not be cached
    logic        discard_q, discard_d;

    logic        sel_blank;
    logic [25:0] sel_addr;
    logic        hit;
    logic        pending;
    logic        resolve_ok;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] n);
        logic [7:0] b;
        case (n)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign mem_request = (state_q == REQ);
    assign mem_address = mem_address_q;
    assign pixel_out   = pixel_q;
    assign underrun    = underrun_q;

    // Priority select: the highest-numbered active layer wins.
    always_comb begin
        sel_blank = 1'b1;
        sel_addr  = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (layer_active[i]) begin
                sel_blank = 1'b0;
                sel_addr  = layer_address[26*i +: 26];
            end
        end
    end

    // Next-state logic: job resolution, fetch FSM, cache fill, pixel output stage.
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        pixel_d       = pixel_q;
        underrun_d    = underrun_q;
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        job_addr_d    = job_addr_q;
        job_blank_d   = job_blank_q;
        job_valid_d   = job_valid_q;
        ready_d       = ready_q;
        result_d      = result_q;
        fetch_cur_d   = fetch_cur_q;
        discard_d     = discard_q;

        hit        = cache_valid_q && (cache_tag_q == job_addr_q[25:2]);
        pending    = job_valid_q && !ready_q;
        // A job is only resolved in cycles where it is not being replaced or flushed.
        resolve_ok = pending && !next_pixel && !new_frame;

        if (resolve_ok) begin
            if (job_blank_q) begin
                ready_d  = 1'b1;
                result_d = '0;
            end else if (hit) begin
                ready_d  = 1'b1;
                result_d = pick_byte(cache_data_q, job_addr_q[1:0]);
            end
        end

        case (state_q)
            IDLE: begin
                if (resolve_ok && !job_blank_q && !hit) begin
                    state_d       = REQ;
                    mem_address_d = {job_addr_q[25:2], 2'b00};
                    fetch_cur_d   = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q) begin
                        cache_valid_d = 1'b1;
                        cache_tag_d   = mem_address_q[25:2];
                        cache_data_d  = mem_rdata;
                        if (fetch_cur_q && resolve_ok) begin
                            ready_d  = 1'b1;
                            result_d = pick_byte(mem_rdata, job_addr_q[1:0]);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // new_frame overrides anything the fill above did to the cache valid bit,
        // and marks a still-open transaction so its data is dropped on arrival.
        if (new_frame) begin
            cache_valid_d = 1'b0;
            job_valid_d   = 1'b0;
            ready_d       = 1'b0;
            underrun_d    = 1'b0;
            fetch_cur_d   = 1'b0;
            if ((state_q == REQ) || ((state_q == WAIT) && !mem_rvalid)) begin
                discard_d = 1'b1;
            end
        end else if (next_pixel) begin
            if (job_valid_q && ready_q) begin
                pixel_d = result_q;
            end else begin
                pixel_d = '0;
                if (job_valid_q) begin
                    underrun_d = 1'b1;
                end
            end
            job_addr_d  = sel_addr;
            job_blank_d = sel_blank;
            job_valid_d = 1'b1;
            ready_d     = 1'b0;
            fetch_cur_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            pixel_q       <= '0;
            underrun_q    <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
            job_addr_q    <= '0;
            job_blank_q   <= 1'b0;
            job_valid_q   <= 1'b0;
            ready_q       <= 1'b0;
            result_q      <= '0;
            fetch_cur_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            pixel_q       <= pixel_d;
            underrun_q    <= underrun_d;
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
            job_addr_q    <= job_addr_d;
            job_blank_q   <= job_blank_d;
            job_valid_q   <= job_valid_d;
            ready_q       <= ready_d;
            result_q      <= result_d;
            fetch_cur_q   <= fetch_cur_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Sits directly downstream of the per-layer address generators in the VGA pipeline.
- Each pixel, it selects the topmost active layer and turns that layer's byte address into an 8-bit pixel value.
- Pixel bytes come from a one-word read cache or a 32-bit SDRAM read over a request/ack port.
- One pixel of latency between address capture and pixel_out; deadline misses are flagged on a sticky underrun bit.

Parameters:
NUM_LAYERS, 8, number of layer inputs; index NUM_LAYERS-1 has highest priority.

Ports:
clock  in  1  125MHz system clock
reset  in  1  reset, synchronous, active-high
next_pixel  in  1  pulse, advance to next pixel (same pulse the layers use)
new_frame  in  1  pulse, start of frame
layer_active  in  NUM_LAYERS  bit i = layer i covers current pixel
layer_address  in  26*NUM_LAYERS  layer i byte address in bits [26*i+25:26*i]
mem_request  out  1  read request, held until mem_ack
mem_address  out  26  word-aligned read address, bits [1:0] = 0
mem_ack  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid (one per accepted request, in order)
mem_rdata  in  32  read data, little-endian bytes
pixel_out  out  8  pixel for display, updated only on next_pixel
underrun  out  1  sticky: a pixel was not ready by its deadline

Behaviour:
- Reset: mem_request=0, mem_address=0, pixel_out=0, underrun=0, FSM=IDLE, cache invalid, job invalid, result not ready.
- Selection (combinational): highest i with layer_active[i]=1. If none, the job is BLANK (value 0, no memory access).
- On next_pixel (no new_frame):
  - Output stage first:
    - result ready: pixel_out <= result.
    - job valid but not ready: pixel_out <= 0, underrun <= 1.
    - no job valid: pixel_out <= 0, underrun unchanged.
  - Then capture a new job: job_addr, job_blank, job_valid=1, ready=0.
- Job resolution, starting the cycle after capture:
  - BLANK: ready, result 0.
  - Cache hit (cache valid, tag == job_addr[25:2]): ready, result = cached byte job_addr[1:0].
  - Miss and FSM IDLE: FSM -> REQ.
- FSM:
  - IDLE: handles jobs as above.
  - REQ: mem_request=1, mem_address={job_addr[25:2],2'b00}. mem_address is stable while mem_request is high. mem_ack in the same cycle -> WAIT.
  - WAIT: on mem_rvalid, cache <= mem_rdata and tag <= fetched word address, then -> IDLE.
    - If the fetched word belongs to the current job, result = byte[job_addr[1:0]] and ready.
    - If a newer job was captured meanwhile (stale fetch): no result for the stale job. The new job is re-evaluated against the updated cache in the IDLE cycle that follows.
- Deadline: a miss must complete before the next next_pixel, else that pixel outputs 0 and underrun sets.
- Byte order: byte n = mem_rdata[8n+7:8n].
- new_frame:
  - Invalidates cache and job, clears underrun.
  - Takes priority over a simultaneous next_pixel: no capture, pixel_out unchanged.
  - An outstanding transaction (REQ or WAIT) still runs to mem_rvalid. Its data is discarded and not cached.
  - REQ is never dropped once asserted.
- Reset mid-transaction: FSM returns to IDLE immediately. The memory side must tolerate an abandoned request.
- Widths: tag compare on bits [25:2] only; no address arithmetic in this block.

Test Plan:
- No layer active at any pixel, 3 next_pixel pulses -> pixel_out=0 each time, mem_request never asserted, underrun=0.
- Layer 0 active, address 0x3f80000, mem_ack 2 cycles after request, rvalid 4 cycles later with rdata=0x44332211, next_pixel every 5+ cycles thereafter -> mem_address=0x3f80000; on the following next_pixel, pixel_out=0x11.
- Addresses 0x3f80001, 0x3f80002, 0x3f80003 on consecutive pixels after the fetch above -> no mem_request; pixel_out 0x22, 0x33, 0x44.
- Layers 0 and 3 active, layer 3 address 0x0001005, rdata=0xAABBCCDD -> mem_address=0x0001004, pixel_out=0xCC.
- Miss with rvalid withheld past next next_pixel -> pixel_out=0, underrun=1. underrun stays 1 until new_frame, then reads 0.
- new_frame while in WAIT, then a pixel at the same word -> FSM finishes the old read, cache not filled, new request issued for the same word.
